// File: rtl/bias_act_quant.sv
// Bias-add, ReLU and requantization stage that streams one vector out element by element.
// Define LEAKY_RELU_EN to replace ReLU with a leaky ReLU (negative sums scaled by 1/8).
module bias_act_quant #(
    parameter int ROWS      = 6,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*ACC_WIDTH-1:0]  in_vector,
    input  logic [ROWS*ACC_WIDTH-1:0]  bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic [$clog2(ROWS)-1:0]    out_index,
    output logic                       out_last,
    output logic                       sat_flag
);
    localparam int IDX_W = $clog2(ROWS);
    localparam int SW    = ACC_WIDTH + 2;
    localparam int RND   = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
    localparam logic signed [SW-1:0] RND_S   = SW'(RND);
    localparam logic signed [SW-1:0] OUT_MAX = SW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] OUT_MIN = SW'(-(1 << (OUT_WIDTH - 1)));

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // Returns {saturated, quantized element} for one accumulator/bias pair.
    function automatic logic [OUT_WIDTH:0] quant(input logic [ACC_WIDTH-1:0] x,
                                                 input logic [ACC_WIDTH-1:0] b);
        logic signed [ACC_WIDTH:0] s;
        logic signed [SW-1:0]      r;
        logic                      sat;
        logic [OUT_WIDTH-1:0]      y;
        s = signed'({x[ACC_WIDTH-1], x}) + signed'({b[ACC_WIDTH-1], b});
        if (s[ACC_WIDTH]) begin
`ifdef LEAKY_RELU_EN
            s = s >>> 3;
`else
            s = '0;
`endif
        end
        r = signed'({s[ACC_WIDTH], s}) + RND_S;
        r = r >>> SHIFT;
        if (r > OUT_MAX) begin
            y   = OUT_MAX[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (r < OUT_MIN) begin
            y   = OUT_MIN[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else begin
            y   = r[OUT_WIDTH-1:0];
            sat = 1'b0;
        end
        return {sat, y};
    endfunction

    logic [0:0]                state_q, state_d;
    logic [ROWS*ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ROWS*ACC_WIDTH-1:0] bias_q, bias_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]      out_data_q, out_data_d;
    logic [IDX_W-1:0]          out_index_q, out_index_d;
    logic                      out_last_q, out_last_d;
    logic                      sat_q, sat_d;

    logic [IDX_W-1:0]          nxt_idx;
    logic [OUT_WIDTH:0]        q_first;
    logic [OUT_WIDTH:0]        q_next;

    // Element 0 comes straight from the inputs so it is ready on the capture edge.
    assign nxt_idx = out_index_q + 1'b1;
    assign q_first = quant(in_vector[0 +: ACC_WIDTH], bias[0 +: ACC_WIDTH]);
    assign q_next  = quant(acc_q[nxt_idx*ACC_WIDTH +: ACC_WIDTH],
                           bias_q[nxt_idx*ACC_WIDTH +: ACC_WIDTH]);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d       = in_vector;
                    bias_d      = bias;
                    out_valid_d = 1'b1;
                    out_data_d  = q_first[OUT_WIDTH-1:0];
                    out_index_d = '0;
                    out_last_d  = (ROWS == 1);
                    sat_d       = q_first[OUT_WIDTH];
                    state_d     = S_STREAM;
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        out_data_d  = q_next[OUT_WIDTH-1:0];
                        out_index_d = nxt_idx;
                        out_last_d  = (nxt_idx == IDX_W'(ROWS - 1));
                        sat_d       = sat_q | q_next[OUT_WIDTH];
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
        end
    end

    // NOTE: the captured vector needs no reset; it is only read after a fresh capture.
    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        bias_q <= bias_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_bias_act_quant.sv
// Directed self-checking bench for bias_act_quant at default parameters.
module tb_bias_act_quant;
    localparam int ROWS = 6;
    localparam int AW   = 16;
    localparam int OW   = 8;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [ROWS*AW-1:0] in_vector;
    logic [ROWS*AW-1:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic [OW-1:0]      out_data;
    logic [2:0]         out_index;
    logic               out_last;
    logic               sat_flag;

    int errors = 0;
    int checks = 0;

    bias_act_quant dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector while idle and drop in_valid after the capture edge.
    task automatic send(input string tag, input logic [ROWS*AW-1:0] v, input logic [ROWS*AW-1:0] b);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_vector = v;
        bias      = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_vector = {ROWS{16'hDEAD}};
        bias      = {ROWS{16'hBEEF}};
    endtask

    // Check the beat currently presented, then advance one clock.
    task automatic beat(input string tag, input logic [OW-1:0] d, input int idx, input logic sat);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".index"}, 32'(out_index), 32'(idx));
        check({tag, ".last"},  32'(out_last),  32'(idx == ROWS - 1));
        check({tag, ".sat"},   32'(sat_flag),  32'(sat));
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        tick();
    endtask

    logic [OW-1:0]      neg_exp;
    logic [ROWS*AW-1:0] ramp_vec;
    logic [ROWS*AW-1:0] round_vec;
    logic [ROWS*AW-1:0] round_bias;

    initial begin
`ifdef LEAKY_RELU_EN
        neg_exp = 8'hFC;
`else
        neg_exp = 8'h00;
`endif
        // element i = 32*i -> (32i+8)>>>4 = 2i
        ramp_vec   = {16'd160, 16'd128, 16'd96, 16'd64, 16'd32, 16'd0};
        // 7->0, 8->1, 23->1, 24->2, -10+5 ->0, 2024+8=2032 ->127 without clamping
        round_vec  = {16'd2024, -16'sd10, 16'd24, 16'd23, 16'd8, 16'd7};
        round_bias = {16'd8, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_vector = '0;
        bias      = '0;

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_index", 32'(out_index), 32'd0);
        check("rst.out_last",  32'(out_last),  32'd0);
        check("rst.sat_flag",  32'(sat_flag),  32'd0);
        reset = 1'b1;
        tick();

        // 2. uniform vector, back-to-back beats
        send("t2", {ROWS{16'd256}}, {ROWS{16'd16}});
        for (int i = 0; i < ROWS; i++) beat("t2", 8'd17, i, 1'b0);
        check("t2.done.valid", 32'(out_valid), 32'd0);
        check("t2.done.in_ready", 32'(in_ready), 32'd1);

        // 3. negative sums
        send("t3", {ROWS{-16'sd500}}, '0);
        for (int i = 0; i < ROWS; i++) beat("t3", neg_exp, i, 1'b0);

        // 4. saturation, then a clean vector clears the flag
        send("t4", {ROWS{16'h7FFF}}, {ROWS{16'h7FFF}});
        for (int i = 0; i < ROWS; i++) beat("t4", 8'd127, i, 1'b1);
        send("t4b", {ROWS{16'd256}}, {ROWS{16'd16}});
        for (int i = 0; i < ROWS; i++) beat("t4b", 8'd17, i, 1'b0);

        // rounding boundaries
        send("rnd", round_vec, round_bias);
        beat("rnd0", 8'd0, 0, 1'b0);
        beat("rnd1", 8'd1, 1, 1'b0);
        beat("rnd2", 8'd1, 2, 1'b0);
        beat("rnd3", 8'd2, 3, 1'b0);
        beat("rnd4", 8'd0, 4, 1'b0);
        beat("rnd5", 8'd127, 5, 1'b0);

        // 5. back-pressure while index 2 is presented
        send("t5", ramp_vec, '0);
        beat("t5", 8'd0, 0, 1'b0);
        beat("t5", 8'd2, 1, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5.hold.valid", 32'(out_valid), 32'd1);
            check("t5.hold.data",  32'(out_data),  32'd4);
            check("t5.hold.index", 32'(out_index), 32'd2);
            check("t5.hold.last",  32'(out_last),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < ROWS; i++) beat("t5", 8'(2 * i), i, 1'b0);
        check("t5.done.valid", 32'(out_valid), 32'd0);

        // 6. reset during beat 3
        send("t6", {ROWS{16'd256}}, {ROWS{16'd16}});
        for (int i = 0; i < 3; i++) beat("t6", 8'd17, i, 1'b0);
        check("t6.pre.index", 32'(out_index), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6.rst.valid",    32'(out_valid), 32'd0);
        check("t6.rst.last",     32'(out_last),  32'd0);
        check("t6.rst.in_ready", 32'(in_ready),  32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t6.post.in_ready", 32'(in_ready),  32'd1);
        check("t6.post.valid",    32'(out_valid), 32'd0);
        send("t6b", ramp_vec, '0);
        for (int i = 0; i < ROWS; i++) beat("t6b", 8'(2 * i), i, 1'b0);
        check("t6b.done.in_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
